// File: rtl/xor_alu_pkg.sv
// xor_alu_pkg: shared constants and types for the XOR datapath blocks.
package xor_alu_pkg;
  localparam logic [7:0] DESCR_POLY_DEFAULT = 8'hB8;
  localparam logic [7:0] DESCR_SEED_DEFAULT = 8'hFF;
  typedef enum logic {IDLE, RUN} descr_state_t;
endpackage

// File: rtl/lfsr_step8.sv
// lfsr_step8: advances an 8-bit Galois LFSR by eight single-bit steps in one combinational pass.
module lfsr_step8 #(
  parameter logic [7:0] POLY = 8'hB8
) (
  input  logic [7:0] s,
  output logic [7:0] n
);
  logic [7:0] chain [0:8];
  assign chain[0] = s;
  for (genvar i = 0; i < 8; i++) begin : g_step
    assign chain[i+1] = (chain[i] >> 1) ^ (chain[i][0] ? POLY : 8'h00);
  end
  assign n = chain[8];
endmodule

// File: rtl/xor_descrambler_8_bit.sv
// xor_descrambler_8_bit: XORs scrambled bytes with a Galois LFSR keystream behind valid/ready handshakes.
// Define XOR_DESCRAMBLER_COUNT_EN to build the accepted-byte counter; otherwise byte_count reads zero.
module xor_descrambler_8_bit
  import xor_alu_pkg::*;
#(
  parameter logic [7:0] POLY = DESCR_POLY_DEFAULT,
  parameter logic [7:0] SEED = DESCR_SEED_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        seed_load,
  input  logic [7:0]  seed,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic [15:0] byte_count
);
  descr_state_t state, state_next;
  logic [7:0] lfsr, lfsr_next;
  logic accept;
  lfsr_step8 #(.POLY(POLY)) u_step (.s(lfsr), .n(lfsr_next));
  always_comb begin
    state_next = (state == IDLE && seed_load) ? RUN : state;
    in_ready = (state == RUN) && (!out_valid || out_ready);
    accept = in_valid && in_ready;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_next;
  end
  // A reseed overrides the step so a same-cycle accept still used the old keystream byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= SEED;
    else if (seed_load) lfsr <= (seed == 8'h00) ? SEED : seed;
    else if (accept) lfsr <= lfsr_next;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= 8'h00;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data <= in_data ^ lfsr;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
`ifdef XOR_DESCRAMBLER_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) byte_count <= 16'h0000;
    else if (seed_load) byte_count <= 16'h0000;
    else if (accept) byte_count <= byte_count + 16'h0001;
  end
`else
  assign byte_count = 16'h0000;
`endif
endmodule

// File: tb/tb_xor_descrambler_8_bit.sv
// tb_xor_descrambler_8_bit: scoreboard bench with a reference LFSR model checked every falling edge.
module tb_xor_descrambler_8_bit;
  logic clk = 1'b0, rst = 1'b1, seed_load = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] seed = 8'h00, in_data = 8'h00;
  logic in_ready, out_valid;
  logic [7:0] out_data;
  logic [15:0] byte_count;
  int errors = 0, checks = 0;
  logic [7:0] sb [$];
  logic m_run = 1'b0, m_ov = 1'b0, m_acc;
  logic [7:0] m_lfsr = 8'hFF;
  logic [15:0] m_cnt = 16'h0000;

  xor_descrambler_8_bit dut (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_step8(input logic [7:0] s);
    logic [7:0] r = s;
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 8'hB8) : (r >> 1);
    return r;
  endfunction

  function automatic logic [15:0] exp_count();
`ifdef XOR_DESCRAMBLER_COUNT_EN
    return m_cnt;
`else
    return 16'h0000;
`endif
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      check("rst_out_valid", {15'd0, out_valid}, 16'd0);
      check("rst_in_ready", {15'd0, in_ready}, 16'd0);
      check("rst_out_data", {8'd0, out_data}, 16'd0);
      check("rst_count", byte_count, 16'd0);
      m_run = 1'b0; m_ov = 1'b0; m_lfsr = 8'hFF; m_cnt = 16'h0000;
      sb.delete();
    end else begin
      check("in_ready", {15'd0, in_ready}, {15'd0, m_run && (!m_ov || out_ready)});
      check("out_valid", {15'd0, out_valid}, {15'd0, m_ov});
      check("byte_count", byte_count, exp_count());
      if (m_ov) begin
        if (sb.size() == 0) check("sb_empty", 16'd1, 16'd0);
        else begin
          check("out_data", {8'd0, out_data}, {8'd0, sb[0]});
          if (out_ready) void'(sb.pop_front());
        end
      end
      m_acc = in_valid && m_run && (!m_ov || out_ready);
      if (m_acc) sb.push_back(in_data ^ m_lfsr);
      m_ov = m_acc ? 1'b1 : (out_ready ? 1'b0 : m_ov);
      m_cnt = seed_load ? 16'h0000 : (m_acc ? m_cnt + 16'h0001 : m_cnt);
      m_lfsr = seed_load ? ((seed == 8'h00) ? 8'hFF : seed) : (m_acc ? ref_step8(m_lfsr) : m_lfsr);
      m_run = m_run || seed_load;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic reseed(input logic [7:0] v);
    seed_load = 1'b1; seed = v; in_valid = 1'b0;
    cyc();
    seed_load = 1'b0;
  endtask

  initial begin
    repeat (2) cyc();
    rst = 1'b0;
    in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b1;
    repeat (3) cyc();
    check("idle_no_ready", {15'd0, in_ready}, 16'd0);
    check("idle_no_out", {15'd0, out_valid}, 16'd0);
    reseed(8'hFF);
    in_valid = 1'b1; in_data = 8'h00;
    cyc();
    check("ks_first", {8'd0, out_data}, 16'h00FF);
    cyc();
    check("ks_second", {8'd0, out_data}, 16'h0023);
    in_valid = 1'b0;
    cyc();
    reseed(8'hFF);
    in_valid = 1'b1; in_data = 8'hFF;
    cyc();
    check("ff_to_00", {8'd0, out_data}, 16'h0000);
    reseed(8'h00);
    in_valid = 1'b1; in_data = 8'h00;
    cyc();
    check("zero_seed", {8'd0, out_data}, 16'h00FF);
    reseed(8'hFF);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h00;
    cyc();
    repeat (2) begin
      cyc();
      check("bp_hold", {8'd0, out_data}, 16'h00FF);
      check("bp_ready", {15'd0, in_ready}, 16'd0);
    end
    out_ready = 1'b1;
    cyc();
    check("bp_resume", {8'd0, out_data}, 16'h0023);
    in_valid = 1'b0;
    cyc();
    reseed(8'hFF);
    in_valid = 1'b1; in_data = 8'h00;
    cyc();
    seed_load = 1'b1; seed = 8'hFF;
    cyc();
    seed_load = 1'b0;
    check("reseed_old_ks", {8'd0, out_data}, 16'h0023);
    check("reseed_count", byte_count, 16'h0000);
    cyc();
    check("reseed_new_ks", {8'd0, out_data}, 16'h00FF);
    #2 rst = 1'b1;
    #1 check("async_rst", {15'd0, out_valid}, 16'd0);
    cyc();
    rst = 1'b0; in_valid = 1'b0;
    cyc();
    reseed(8'($urandom_range(0, 255)));
    for (int i = 0; i < 60; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data = 8'($urandom_range(0, 255));
      out_ready = ($urandom_range(0, 3) != 0);
      seed_load = ($urandom_range(0, 15) == 0);
      seed = 8'($urandom_range(0, 255));
      cyc();
    end
    seed_load = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
